// File: rtl/axis_packetizer_if.sv
`default_nettype none
// ============================================================================
//  Module      : axis_packetizer_if
//  Description : AXI-Stream beat bundle (valid/ready/data/last) with
//                master and slave views for the packetizer ports.
//  Revision    : 1.0 - initial release
// ============================================================================
interface axis_packetizer_if #(
    parameter int P_DATA_WIDTH = 16
) ();
    logic                    tvalid;
    logic                    tready;
    logic [P_DATA_WIDTH-1:0] tdata;
    logic                    tlast;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        output tready
    );
endinterface
`default_nettype wire

// File: rtl/axis_packetizer.sv
`default_nettype none
// ============================================================================
//  Module      : axis_packetizer
//  Description : Frames an AXI-Stream into packets of at most P_MAX_BEATS
//                data beats. Every packet is closed by a trailer beat
//                (tlast=1) carrying {cause[1:0], seq[5:0], count[7:0]}.
//                Close causes: 00 input tlast, 01 max length, 10 idle timeout.
//                Optional idle timeout enabled by macro AXIS_PKT_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_packetizer #(
    parameter int P_DATA_WIDTH = 16,
    parameter int P_MAX_BEATS  = 16,
    parameter int P_TIMEOUT    = 32
) (
    input  wire               clk,
    input  wire               rst,
    axis_packetizer_if.slave  s_axis,
    axis_packetizer_if.master m_axis
);

    localparam logic [0:0] c_ST_PASS    = 1'b0;
    localparam logic [0:0] c_ST_TRAILER = 1'b1;

    localparam logic [1:0] c_CAUSE_TLAST = 2'b00;
    localparam logic [1:0] c_CAUSE_MAX   = 2'b01;

    logic [0:0]              state_q, state_d;
    logic                    m_tvalid_q, m_tvalid_d;
    logic [P_DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
    logic                    m_tlast_q, m_tlast_d;
    logic [7:0]              beat_cnt_q, beat_cnt_d;
    logic [5:0]              seq_q, seq_d;
    logic [1:0]              cause_q, cause_d;

    logic                    w_out_free;
    logic                    w_s_ready;
    logic                    w_accept;
    logic                    w_close_beat;
    logic                    w_close_idle;
    logic [P_DATA_WIDTH-1:0] w_trailer;

`ifdef AXIS_PKT_TIMEOUT_EN
    localparam logic [1:0]          c_CAUSE_TIMEOUT = 2'b10;
    localparam int                  c_IDLE_W        = $clog2(P_TIMEOUT + 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_ONE      = 1;

    logic [c_IDLE_W-1:0] idle_q, idle_d;

    // Idle timeout fires on the idle cycle that brings the count to P_TIMEOUT;
    // an accepted beat in that cycle wins because it is not idle.
    assign w_close_idle = (state_q == c_ST_PASS) && !w_accept &&
                          (beat_cnt_q != 8'd0) &&
                          (int'(idle_q) + 1 == P_TIMEOUT);
`else
    // Without the timeout a partial packet simply waits for more input.
    logic w_unused_timeout;
    assign w_unused_timeout = (P_TIMEOUT > 0);
    assign w_close_idle     = 1'b0;
`endif

    // The output register can take a new beat when empty or being drained.
    assign w_out_free = !m_tvalid_q || m_axis.tready;
    // Upstream is stalled during reset and for every trailer cycle.
    assign w_s_ready  = !rst && (state_q == c_ST_PASS) && w_out_free;
    assign w_accept   = s_axis.tvalid && w_s_ready;
    // tlast and the length limit are both judged on the incoming beat.
    assign w_close_beat = w_accept &&
                          (s_axis.tlast || (int'(beat_cnt_q) + 1 == P_MAX_BEATS));

    assign s_axis.tready = w_s_ready;
    assign m_axis.tvalid = m_tvalid_q;
    assign m_axis.tdata  = m_tdata_q;
    assign m_axis.tlast  = m_tlast_q;

    // Assemble the trailer word from the closed packet's bookkeeping.
    always_comb begin
        w_trailer        = '0;
        w_trailer[7:0]   = beat_cnt_q;
        w_trailer[13:8]  = seq_q;
        w_trailer[15:14] = cause_q;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_ST_PASS;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: close a packet into TRAILER, leave once the trailer loads.
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_PASS: begin
                if (w_close_beat || w_close_idle) begin
                    state_d = c_ST_TRAILER;
                end
            end
            c_ST_TRAILER: begin
                if (w_out_free) begin
                    state_d = c_ST_PASS;
                end
            end
            default: state_d = c_ST_PASS;
        endcase
    end

    // Output register, counters and close cause for the next cycle.
    always_comb begin
        m_tvalid_d = m_tvalid_q;
        m_tdata_d  = m_tdata_q;
        m_tlast_d  = m_tlast_q;
        beat_cnt_d = beat_cnt_q;
        seq_d      = seq_q;
        cause_d    = cause_q;

        if (w_out_free) begin
            m_tvalid_d = 1'b0;
        end

        case (state_q)
            c_ST_PASS: begin
                if (w_accept) begin
                    m_tvalid_d = 1'b1;
                    m_tdata_d  = s_axis.tdata;
                    m_tlast_d  = 1'b0;
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (w_close_beat) begin
                        cause_d = s_axis.tlast ? c_CAUSE_TLAST : c_CAUSE_MAX;
                    end
                end
            end
            c_ST_TRAILER: begin
                if (w_out_free) begin
                    m_tvalid_d = 1'b1;
                    m_tdata_d  = w_trailer;
                    m_tlast_d  = 1'b1;
                    seq_d      = seq_q + 6'd1;
                    beat_cnt_d = 8'd0;
                end
            end
            default: ;
        endcase

`ifdef AXIS_PKT_TIMEOUT_EN
        idle_d = idle_q;
        if (w_accept || w_close_idle || (state_q != c_ST_PASS)) begin
            idle_d = '0;
        end else if (beat_cnt_q != 8'd0) begin
            idle_d = idle_q + c_IDLE_ONE;
        end
        if (w_close_idle) begin
            cause_d = c_CAUSE_TIMEOUT;
        end
`endif
    end

    // Datapath registers; reset drops any partial packet and pending beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tlast_q  <= 1'b0;
            beat_cnt_q <= 8'd0;
            seq_q      <= 6'd0;
            cause_q    <= 2'b00;
`ifdef AXIS_PKT_TIMEOUT_EN
            idle_q     <= '0;
`endif
        end else begin
            m_tvalid_q <= m_tvalid_d;
            m_tdata_q  <= m_tdata_d;
            m_tlast_q  <= m_tlast_d;
            beat_cnt_q <= beat_cnt_d;
            seq_q      <= seq_d;
            cause_q    <= cause_d;
`ifdef AXIS_PKT_TIMEOUT_EN
            idle_q     <= idle_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_packetizer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_packetizer
//  Description : Self-checking bench for axis_packetizer. A packet-level
//                reference model turns accepted input beats into the expected
//                output stream; directed scenarios plus a randomized phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_packetizer;

    localparam int P_DATA_WIDTH = 16;
    localparam int P_MAX_BEATS  = 4;
    localparam int P_TIMEOUT    = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    axis_packetizer_if #(.P_DATA_WIDTH(P_DATA_WIDTH)) s_if ();
    axis_packetizer_if #(.P_DATA_WIDTH(P_DATA_WIDTH)) m_if ();

    axis_packetizer #(
        .P_DATA_WIDTH (P_DATA_WIDTH),
        .P_MAX_BEATS  (P_MAX_BEATS),
        .P_TIMEOUT    (P_TIMEOUT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .s_axis (s_if),
        .m_axis (m_if)
    );

    int          n_total = 0;
    int          n_bad   = 0;
    logic [16:0] exp_q[$];      // expected {tlast, tdata} output beats
    logic [15:0] trail_log[$];  // trailers seen since the last reset
    int          mdl_cnt  = 0;
    int          mdl_seq  = 0;
    int          mdl_idle = 0;
    logic        prev_stall = 1'b0;
    logic [16:0] prev_beat  = '0;
    logic [16:0] mon_e;
    logic        rand_done;
    int          lat;
    logic        found;
    int          gap;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h want=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: close the current packet and queue its trailer.
    task automatic mdl_close(input logic [1:0] cause);
        exp_q.push_back({1'b1, cause, 6'(mdl_seq), 8'(mdl_cnt)});
        mdl_seq  = (mdl_seq + 1) % 64;
        mdl_cnt  = 0;
        mdl_idle = 0;
    endtask

    // Monitor + reference model, sampled mid-cycle (handshakes of this cycle).
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            trail_log.delete();
            mdl_cnt    = 0;
            mdl_seq    = 0;
            mdl_idle   = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("hold_valid", 32'(m_if.tvalid), 32'd1);
                check_eq("hold_data", 32'({m_if.tlast, m_if.tdata}), 32'(prev_beat));
            end
            if (m_if.tvalid && m_if.tready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_beat_qlen", 32'(exp_q.size()), 32'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("out_beat", 32'({m_if.tlast, m_if.tdata}), 32'(mon_e));
                end
                if (m_if.tlast) trail_log.push_back(m_if.tdata);
            end
            prev_stall = m_if.tvalid && !m_if.tready;
            prev_beat  = {m_if.tlast, m_if.tdata};

            if (s_if.tvalid && s_if.tready) begin
                exp_q.push_back({1'b0, s_if.tdata});
                mdl_cnt++;
                mdl_idle = 0;
                if (s_if.tlast)                 mdl_close(2'b00);
                else if (mdl_cnt == P_MAX_BEATS) mdl_close(2'b01);
            end
`ifdef AXIS_PKT_TIMEOUT_EN
            else if (mdl_cnt > 0) begin
                mdl_idle++;
                if (mdl_idle == P_TIMEOUT) mdl_close(2'b10);
            end
`endif
        end
    end

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic do_reset();
        rst         = 1'b1;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tdata  = '0;
        m_if.tready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic send_beat(input logic [15:0] d, input logic l);
        int   waited = 0;
        logic acc    = 1'b0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tlast  = l;
        while (!acc && waited < 200) begin
            @(negedge clk);
            acc = s_if.tready;
            @(posedge clk); #1;
            waited++;
        end
        if (!acc) check_eq("send_handshake", 32'(acc), 32'd1);
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        m_if.tready = 1'b1;
        s_if.tvalid = 1'b0;
        while ((exp_q.size() != 0 || m_if.tvalid) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_trailer(input string tag, input int idx, input logic [15:0] exp);
        if (trail_log.size() > idx) check_eq(tag, 32'(trail_log[idx]), 32'(exp));
        else check_eq({tag, "_count"}, 32'(trail_log.size()), 32'(idx + 1));
    endtask

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        rand_done   = 1'b0;

        // Reset state: outputs cleared, upstream stalled while rst is high.
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
        check_eq("rst_m_tdata", 32'(m_if.tdata), 32'd0);
        check_eq("rst_m_tlast", 32'(m_if.tlast), 32'd0);
        check_eq("rst_s_tready", 32'(s_if.tready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_s_tready", 32'(s_if.tready), 32'd1);
        @(posedge clk); #1;

        // Short frame closed by tlast.
        send_beat(16'h0011, 1'b0);
        send_beat(16'h0022, 1'b0);
        send_beat(16'h0033, 1'b1);
        drain("short_drain");
        check_trailer("short_trailer", 0, 16'h0003);

        // Max-length split then tlast close.
        do_reset();
        for (int i = 1; i <= 6; i++) send_beat(16'(i), (i == 6));
        drain("split_drain");
        check_trailer("split_trailer0", 0, 16'h4004);
        check_trailer("split_trailer1", 1, 16'h0102);

        // Backpressure: pending beat held stable, upstream stalled.
        do_reset();
        m_if.tready = 1'b0;
        send_beat(16'h00A5, 1'b0);
        s_if.tvalid = 1'b1;
        s_if.tdata  = 16'h00A6;
        s_if.tlast  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_m_tvalid", 32'(m_if.tvalid), 32'd1);
            check_eq("bp_m_tdata", 32'(m_if.tdata), 32'h00A5);
            check_eq("bp_s_tready", 32'(s_if.tready), 32'd0);
            @(posedge clk); #1;
        end
        m_if.tready = 1'b1;
        send_beat(16'h00A6, 1'b1);
        drain("bp_drain");
        check_trailer("bp_trailer", 0, 16'h0002);

        // Idle behaviour of a partial packet.
        do_reset();
        send_beat(16'h0101, 1'b0);
        send_beat(16'h0202, 1'b0);
`ifdef AXIS_PKT_TIMEOUT_EN
        lat   = 0;
        found = 1'b0;
        while (!found && lat < 20) begin
            @(negedge clk);
            lat++;
            if (m_if.tvalid && m_if.tlast) found = 1'b1;
            @(posedge clk); #1;
        end
        check_eq("tmo_seen", 32'(found), 32'd1);
        check_eq("tmo_latency_window",
                 32'((lat >= P_TIMEOUT + 1) && (lat <= P_TIMEOUT + 2)), 32'd1);
        drain("tmo_drain");
        check_trailer("tmo_trailer", 0, 16'h8002);
`else
        repeat (100) @(posedge clk);
        #1;
        check_eq("no_tmo_trailer", 32'(trail_log.size()), 32'd0);
        send_beat(16'h0303, 1'b1);
        drain("notmo_drain");
        check_trailer("notmo_trailer", 0, 16'h0003);
`endif

        // Reset in the middle of a packet.
        do_reset();
        send_beat(16'h0055, 1'b0);
        send_beat(16'h0066, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_s_tready", 32'(s_if.tready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        send_beat(16'h0077, 1'b1);
        drain("midrst_drain");
        check_eq("midrst_trailers", 32'(trail_log.size()), 32'd1);
        check_trailer("midrst_trailer", 0, 16'h0001);

        // Sequence wrap across 65 single-beat frames.
        do_reset();
        for (int i = 0; i < 65; i++) send_beat(16'($urandom), 1'b1);
        drain("wrap_drain");
        check_trailer("wrap_trailer64", 63, 16'h3F01);
        check_trailer("wrap_trailer65", 64, 16'h0001);

        // Randomized traffic with random downstream backpressure.
        do_reset();
        fork
            begin
                while (!rand_done) begin
                    m_if.tready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
                m_if.tready = 1'b1;
            end
            begin
                for (int i = 0; i < 300; i++) begin
                    send_beat(16'($urandom), ($urandom_range(0, 3) == 0));
                    gap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(9, 12))
                                                      : int'($urandom_range(0, 2));
                    repeat (gap) @(posedge clk);
                    #0;
                end
                rand_done = 1'b1;
            end
        join
        drain("rand_drain");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire

// File: doc/axis_packetizer.md
# axis_packetizer

- Downstream neighbour of the synchronous AXI-Stream FIFO: drains its master port and frames the stream into bounded packets.
- Each packet is closed by a trailer beat carrying beat count, sequence number and close cause.
- Feeds link/DMA stages that need bounded packet sizes and explicit frame boundaries.

## Interface
- P_DATA_WIDTH, 16: data width; must be ≥ 16.
- P_MAX_BEATS, 16: maximum data beats per packet, 1..255.
- P_TIMEOUT, 32: idle cycles before a partial packet is closed, ≥ 1; used only with the timeout feature.
- clk  input  1  clock; all logic on posedge.
- rst  input  1  reset; synchronous and active-high.
- s_axis_tvalid  input  1  upstream beat valid.
- s_axis_tready  output  1  upstream beat accepted when high with tvalid.
- s_axis_tdata  input  P_DATA_WIDTH  upstream data.
- s_axis_tlast  input  1  upstream end of frame.
- m_axis_tvalid  output  1  downstream beat valid (registered).
- m_axis_tready  input  1  downstream ready.
- m_axis_tdata  output  P_DATA_WIDTH  data or trailer (registered).
- m_axis_tlast  output  1  high only on trailer beats (registered).

## Operation
- States:
  - PASS: forwards data beats.
  - TRAILER: waits to load the trailer.
- Output register is free when `!m_axis_tvalid || m_axis_tready`.
- Handshake:
  - s_axis_tready = (state == PASS) && output register free; combinational.
  - m_axis_tvalid/tdata/tlast change only when the output register is free.
  - Once m_axis_tvalid is high, it stays high with stable data until accepted.
- Data beat:
  - Accepted beat is copied to m_axis_tdata with m_axis_tlast = 0.
  - Input tlast is never forwarded.
  - beat_cnt increments by 1.
- Close conditions, evaluated on the accepted beat:
  - s_axis_tlast = 1 → cause 2'b00.
  - beat_cnt + 1 == P_MAX_BEATS → cause 2'b01.
  - tlast wins if both apply.
  - On close: latch cause and final count, go to TRAILER.
- TRAILER state:
  - When the output register is free, load the trailer with m_axis_tlast = 1.
  - Then seq increments mod 64, beat_cnt clears, return to PASS.
- Trailer format:
  - [7:0] beat count, 1..P_MAX_BEATS.
  - [13:8] seq[5:0].
  - [15:14] cause.
  - [P_DATA_WIDTH-1:16] zero.
- Counters:
  - beat_cnt is 8 bits and never exceeds P_MAX_BEATS.
  - seq is 6 bits and wraps 63 → 0 with no other effect.
- No empty packets: a trailer is never emitted with count 0.

## Timing
- Reset values:
  - m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tlast = 0.
  - s_axis_tready = 0 during the rst cycle, then 1 the first cycle after.
  - state = PASS, beat_cnt = 0, seq = 0, idle counter = 0.
- Data latency: 1 cycle from input acceptance to m_axis_tvalid.
- Trailer latency: loaded in the first free cycle after the closing data beat is accepted downstream. With m_axis_tready held high, this is the cycle after the closing beat appears on the output.
- Input bubble: s_axis_tready is low for exactly the TRAILER cycles, ≥ 1 per packet.
- Full throughput otherwise: one beat per cycle with m_axis_tready high.
- Reset mid-packet:
  - Partial packet and any pending output beat are dropped.
  - No trailer is emitted; seq restarts at 0.

## Configuration
- AXIS_PKT_TIMEOUT_EN defined:
  - In PASS with beat_cnt > 0, the idle counter increments on every cycle with no accepted input beat.
  - The idle counter clears on any accepted beat and on close.
  - When it reaches P_TIMEOUT, go to TRAILER with cause 2'b10 and the current count.
  - An accepted beat in the same cycle the counter would reach P_TIMEOUT takes priority: the beat is accepted and the counter clears.
  - Idle means no accepted beat; cycles lost to downstream backpressure also count as idle.
- AXIS_PKT_TIMEOUT_EN not defined:
  - No idle counter logic; cause 2'b10 never occurs.
  - A partial packet waits indefinitely.

## Test plan
Common settings: P_DATA_WIDTH=16, P_MAX_BEATS=4, P_TIMEOUT=8, reset before each scenario, m_axis_tready=1 unless stated.
- Short frame: 0x0011, 0x0022, 0x0033 with tlast on the third → output 0x0011, 0x0022, 0x0033 (tlast 0), then 0x0003 (tlast 1).
- Max-length split: 6 beats 0x0001..0x0006, tlast on the sixth → 0x0001..0x0004, trailer 0x4004; then 0x0005, 0x0006, trailer 0x0102.
- Backpressure: hold m_axis_tready=0 for 5 cycles with an output beat pending → m_axis_tvalid=1, tdata stable, s_axis_tready=0. Releasing m_axis_tready resumes with no loss or duplication.
- Timeout (macro defined): 2 beats, then s_axis_tvalid=0 → trailer 0x8002 becomes valid 8 idle cycles after the second beat's acceptance. Macro undefined: no trailer within 100 cycles.
- Reset mid-packet: 2 beats, assert rst for 1 cycle, then a 1-beat frame with tlast → only 0x????, trailer 0x0001 after reset; seq is 0.
- Seq wrap: 65 one-beat tlast frames → 64th trailer 0x3F01, 65th trailer 0x0001.
